// File: rtl/controlador_rpn_pkg.sv
// Shared types for the RPN stack sequencer: opcodes, error codes, FSM states, arity helper.
// Unary opcodes 101/110 are enabled only when RPN_UNARIAS_EN is defined.
package rpn_pkg;

   typedef enum logic [2:0] {
      OP_SOMA  = 3'b000,
      OP_SUB   = 3'b001,
      OP_AND   = 3'b010,
      OP_OR    = 3'b011,
      OP_XOR   = 3'b100,
      OP_NOT   = 3'b101,
      OP_NEG   = 3'b110,
      OP_PASSA = 3'b111
   } opcode_t;

   typedef enum logic [1:0] {
      ERR_NENHUM    = 2'b00,
      ERR_OVERFLOW  = 2'b01,
      ERR_UNDERFLOW = 2'b10
   } erro_t;

   typedef enum logic [2:0] {
      OCIOSO,
      EMPILHA,
      LE_OPERANDOS,
      GRAVA,
      ERRO
   } estado_t;

`ifdef RPN_UNARIAS_EN
   localparam bit UNARIAS_EN = 1'b1;
`else
   localparam bit UNARIAS_EN = 1'b0;
`endif

   function automatic logic eh_unaria(input logic [2:0] op);
      return UNARIAS_EN && ((op == OP_NOT) || (op == OP_NEG));
   endfunction

endpackage

// File: rtl/controlador_rpn_if.sv
// Command strobes from the front end and control outputs towards the stack datapath.
interface controlador_rpn_if #(
   parameter int PROFUNDIDADE = 4,
   parameter int LARGURA_END  = $clog2(PROFUNDIDADE)
);
   localparam int LARGURA_CNT = $clog2(PROFUNDIDADE) + 1;

   logic                    cmd_numero;
   logic                    cmd_operacao;
   logic [2:0]              operacao;
   logic                    cmd_executar;
   logic                    cmd_limpa;
   logic [PROFUNDIDADE-1:0] reg_load;
   logic                    mux_sel;
   logic [LARGURA_END-1:0]  reg_sel_a;
   logic [LARGURA_END-1:0]  reg_sel_b;
   logic [2:0]              ula_op;
   logic [LARGURA_CNT-1:0]  profundidade;
   logic                    pilha_vazia;
   logic                    pilha_cheia;
   logic                    ocupado;
   logic                    erro;
   logic [1:0]              codigo_erro;

   modport master (
      output cmd_numero, cmd_operacao, operacao, cmd_executar, cmd_limpa,
      input  reg_load, mux_sel, reg_sel_a, reg_sel_b, ula_op, profundidade,
             pilha_vazia, pilha_cheia, ocupado, erro, codigo_erro
   );

   modport slave (
      input  cmd_numero, cmd_operacao, operacao, cmd_executar, cmd_limpa,
      output reg_load, mux_sel, reg_sel_a, reg_sel_b, ula_op, profundidade,
             pilha_vazia, pilha_cheia, ocupado, erro, codigo_erro
   );
endinterface

// File: rtl/controlador_rpn_decodificador_2_4.sv
// 2-to-4 one-hot decoder with enable; drives the stack cell load strobes.
module decodificador_2_4 (
   input  logic       en,
   input  logic [1:0] endereco,
   output logic [3:0] saida
);
   assign saida = en ? (4'b0001 << endereco) : 4'b0000;
endmodule

// File: rtl/controlador_rpn.sv
// RPN stack sequencer: push/execute/clear FSM, depth counter and error latch.
// Optional unary opcodes (101/110) via `define RPN_UNARIAS_EN.
module controlador_rpn
   import rpn_pkg::*;
#(
   parameter int PROFUNDIDADE = 4,
   parameter int LARGURA_END  = $clog2(PROFUNDIDADE)
) (
   input  logic             clk,
   input  logic             rst,
   controlador_rpn_if.slave bus
);
   localparam int LARGURA_CNT = $clog2(PROFUNDIDADE) + 1;
   localparam logic [LARGURA_CNT-1:0] CNT_MAX  = LARGURA_CNT'(PROFUNDIDADE);
   localparam logic [LARGURA_CNT-1:0] CNT_UM   = LARGURA_CNT'(1);
   localparam logic [LARGURA_CNT-1:0] CNT_DOIS = LARGURA_CNT'(2);

   estado_t                estado, prox_estado;
   erro_t                  cod_erro, prox_cod;
   logic [LARGURA_CNT-1:0] cont;
   logic [2:0]             op_reg, op_efetivo;
   logic                   limpa_ok, wr_en, unaria_reg;
   logic [LARGURA_END-1:0] sel_a, sel_b, end_wr;

   // A same-cycle cmd_operacao decides the arity of the execute it accompanies.
   assign op_efetivo = bus.cmd_operacao ? bus.operacao : op_reg;
   assign unaria_reg = eh_unaria(op_reg);
   assign limpa_ok   = bus.cmd_limpa && ((estado == OCIOSO) || (estado == ERRO));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) estado <= OCIOSO;
      else      estado <= prox_estado;
   end

   always_comb begin
      prox_estado = estado;
      prox_cod    = cod_erro;
      case (estado)
         OCIOSO: begin
            if (bus.cmd_limpa) begin
               prox_cod = ERR_NENHUM;
            end else if (bus.cmd_numero) begin
               if (cont == CNT_MAX) begin
                  prox_estado = ERRO;
                  prox_cod    = ERR_OVERFLOW;
               end else begin
                  prox_estado = EMPILHA;
               end
            end else if (bus.cmd_executar) begin
               if (cont < (eh_unaria(op_efetivo) ? CNT_UM : CNT_DOIS)) begin
                  prox_estado = ERRO;
                  prox_cod    = ERR_UNDERFLOW;
               end else begin
                  prox_estado = LE_OPERANDOS;
               end
            end
         end
         EMPILHA:      prox_estado = OCIOSO;
         LE_OPERANDOS: prox_estado = GRAVA;
         GRAVA:        prox_estado = OCIOSO;
         ERRO: begin
            if (bus.cmd_limpa) begin
               prox_estado = OCIOSO;
               prox_cod    = ERR_NENHUM;
            end
         end
         default:      prox_estado = OCIOSO;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cont     <= '0;
         op_reg   <= '0;
         cod_erro <= ERR_NENHUM;
      end else begin
         cod_erro <= prox_cod;
         if ((estado == OCIOSO) && bus.cmd_operacao) op_reg <= bus.operacao;
         if (limpa_ok)                               cont <= '0;
         else if (estado == EMPILHA)                 cont <= cont + CNT_UM;
         else if ((estado == GRAVA) && !unaria_reg)  cont <= cont - CNT_UM;
      end
   end

   // Idle selects clamp at 0; during an execute the A select doubles as write address.
   always_comb begin
      sel_b = (cont == '0)     ? '0 : LARGURA_END'(cont - CNT_UM);
      sel_a = (cont < CNT_DOIS) ? '0 : LARGURA_END'(cont - CNT_DOIS);
      if (((estado == LE_OPERANDOS) || (estado == GRAVA)) && unaria_reg) sel_a = sel_b;
      end_wr = (estado == EMPILHA) ? LARGURA_END'(cont) : sel_a;
   end

   assign wr_en = (estado == EMPILHA) || (estado == GRAVA);

   generate
      if (PROFUNDIDADE == 4) begin : g_dec
         decodificador_2_4 u_dec (
            .en       (wr_en),
            .endereco (end_wr),
            .saida    (bus.reg_load)
         );
      end else begin : g_dec_gen
         assign bus.reg_load = wr_en ? (PROFUNDIDADE'(1) << end_wr) : '0;
      end
   endgenerate

   assign bus.mux_sel      = (estado == GRAVA);
   assign bus.reg_sel_a    = sel_a;
   assign bus.reg_sel_b    = sel_b;
   assign bus.ula_op       = op_reg;
   assign bus.profundidade = cont;
   assign bus.pilha_vazia  = (cont == '0);
   assign bus.pilha_cheia  = (cont == CNT_MAX);
   assign bus.ocupado      = (estado == EMPILHA) || (estado == LE_OPERANDOS) || (estado == GRAVA);
   assign bus.erro         = (estado == ERRO);
   assign bus.codigo_erro  = cod_erro;

endmodule

// File: tb/tb_controlador_rpn.sv
// Scoreboard bench for controlador_rpn: directed test-plan sequence then random strobes.
module tb_controlador_rpn;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   controlador_rpn_if bus ();
   controlador_rpn dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      int load;
      int mux;
      int sa;
      int sb;
      int op;
      bit chk_sel;
   } esc_t;

   esc_t fila[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // reference model: abstract stack count, latched opcode, error, busy cycles left
   int m_cnt, m_op, m_cod, m_busy;
   bit m_err;

   function automatic bit unaria(int op);
`ifdef RPN_UNARIAS_EN
      return (op == 5) || (op == 6);
`else
      return (op < 0);
`endif
   endfunction

   function automatic int max0(int v);
      return (v < 0) ? 0 : v;
   endfunction

   task automatic chk(string nome, int atual, int esperado);
      n_cmp++;
      if (atual != esperado) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nome, atual, esperado, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_op = 0; m_cod = 0; m_busy = 0; m_err = 0;
   endtask

   task automatic model_step(bit n, bit o, int opv, bit e, bit l);
      int need;
      if (m_busy > 0) begin
         m_busy--;
         return;
      end
      if (o && !m_err) m_op = opv;
      if (l) begin
         m_cnt = 0; m_err = 0; m_cod = 0;
      end else if (m_err) begin
         m_err = 1;
      end else if (n) begin
         if (m_cnt == 4) begin
            m_err = 1; m_cod = 1;
         end else begin
            fila.push_back('{1 << m_cnt, 0, 0, 0, m_op, 1'b0});
            m_cnt++;
            m_busy = 1;
         end
      end else if (e) begin
         need = unaria(m_op) ? 1 : 2;
         if (m_cnt < need) begin
            m_err = 1; m_cod = 2;
         end else if (need == 1) begin
            fila.push_back('{1 << (m_cnt - 1), 1, m_cnt - 1, m_cnt - 1, m_op, 1'b1});
            m_busy = 2;
         end else begin
            fila.push_back('{1 << (m_cnt - 2), 1, m_cnt - 2, m_cnt - 1, m_op, 1'b1});
            m_cnt--;
            m_busy = 2;
         end
      end
   endtask

   task automatic check_flags();
      chk("ocupado", bus.ocupado, (m_busy > 0) ? 1 : 0);
      if (m_busy == 0) begin
         chk("profundidade", bus.profundidade, m_cnt);
         chk("pilha_vazia", bus.pilha_vazia, (m_cnt == 0) ? 1 : 0);
         chk("pilha_cheia", bus.pilha_cheia, (m_cnt == 4) ? 1 : 0);
         chk("erro", bus.erro, m_err);
         chk("codigo_erro", bus.codigo_erro, m_cod);
         chk("reg_load_parado", bus.reg_load, 0);
         chk("mux_sel_parado", bus.mux_sel, 0);
         chk("ula_op", bus.ula_op, m_op);
         if (!m_err) begin
            chk("sel_b_display", bus.reg_sel_b, max0(m_cnt - 1));
            chk("sel_a_display", bus.reg_sel_a, max0(m_cnt - 2));
         end
      end
   endtask

   task automatic check_reset();
      chk("rst_reg_load", bus.reg_load, 0);
      chk("rst_mux_sel", bus.mux_sel, 0);
      chk("rst_sel_a", bus.reg_sel_a, 0);
      chk("rst_sel_b", bus.reg_sel_b, 0);
      chk("rst_ula_op", bus.ula_op, 0);
      chk("rst_profundidade", bus.profundidade, 0);
      chk("rst_vazia", bus.pilha_vazia, 1);
      chk("rst_cheia", bus.pilha_cheia, 0);
      chk("rst_ocupado", bus.ocupado, 0);
      chk("rst_erro", bus.erro, 0);
      chk("rst_codigo", bus.codigo_erro, 0);
   endtask

   // one clock: drive strobes, let the DUT sample them, step the model, check flags
   task automatic ciclo(bit n, bit o, int opv, bit e, bit l);
      bus.cmd_numero   = n;
      bus.cmd_operacao = o;
      bus.operacao     = 3'(opv);
      bus.cmd_executar = e;
      bus.cmd_limpa    = l;
      @(posedge clk);
      model_step(n, o, opv, e, l);
      #1;
      bus.cmd_numero = 0; bus.cmd_operacao = 0; bus.cmd_executar = 0; bus.cmd_limpa = 0;
      @(negedge clk);
      check_flags();
   endtask

   task automatic ocioso();
      ciclo(0, 0, 0, 0, 0);
   endtask

   // monitor: every write strobe must match the oldest expected write
   always @(negedge clk) begin
      if (rst === 1'b1 && bus.reg_load != '0) begin
         if (fila.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL escrita_inesperada: got reg_load=%b, expected no write", bus.reg_load);
         end else begin
            esc_t x;
            x = fila.pop_front();
            chk("wr_reg_load", bus.reg_load, x.load);
            chk("wr_mux_sel", bus.mux_sel, x.mux);
            chk("wr_ula_op", bus.ula_op, x.op);
            if (x.chk_sel) begin
               chk("wr_sel_a", bus.reg_sel_a, x.sa);
               chk("wr_sel_b", bus.reg_sel_b, x.sb);
            end
         end
      end
   end

   initial begin
      rst = 1'b0;
      bus.cmd_numero = 0; bus.cmd_operacao = 0; bus.operacao = 0;
      bus.cmd_executar = 0; bus.cmd_limpa = 0;
      model_reset();
      #12;
      check_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_flags();

      // three pushes, three cycles apart
      repeat (3) begin
         ciclo(1, 0, 0, 0, 0); ocioso(); ocioso();
      end
      // fourth push, then latch-and-execute in the same cycle
      ciclo(1, 0, 0, 0, 0); ocioso();
      ciclo(0, 1, 0, 1, 0); ocioso(); ocioso();
      // fill up, overflow, ignored strobes in error, clear
      ciclo(1, 0, 0, 0, 0); ocioso();
      ciclo(1, 0, 0, 0, 0);
      ciclo(1, 0, 0, 0, 0);
      ciclo(0, 1, 2, 1, 0);
      ciclo(0, 0, 0, 0, 1);
      // binary underflow at count 1
      ciclo(1, 0, 0, 0, 0); ocioso();
      ciclo(0, 1, 1, 1, 0);
      ciclo(0, 0, 0, 0, 1);
      // opcode 101 at count 1: unary write-back or underflow depending on build
      ciclo(1, 0, 0, 0, 0); ocioso();
      ciclo(0, 1, 5, 1, 0); ocioso(); ocioso();
      ciclo(0, 0, 0, 0, 1);
      // push wins over execute; strobe while busy is dropped
      ciclo(1, 0, 0, 0, 0); ocioso();
      ciclo(1, 0, 0, 0, 0); ocioso();
      ciclo(1, 0, 0, 1, 0);
      ciclo(1, 0, 0, 0, 0);
      // reset in the middle of GRAVA
      ciclo(0, 1, 3, 1, 0);
      ocioso();
      chk("em_grava_mux_sel", bus.mux_sel, 1);
      #2 rst = 1'b0;
      #1 check_reset();
      model_reset();
      fila.delete();
      @(negedge clk);
      rst = 1'b1;
      ocioso(); ocioso();

      // random strobes
      repeat (400) begin
         ciclo(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 30),
               int'($urandom_range(0, 7)), ($urandom_range(0, 99) < 30),
               ($urandom_range(0, 99) < 8));
      end
      repeat (3) ocioso();
      chk("fila_final", fila.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
